// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller slice: FSM encoding and defaults.
package fifo_pkg;

    localparam int DATA_BITS_DEF = 10;
    localparam int ADDR_BITS_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        ACTIVE = 2'd2,
        ERROR  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_ptr.sv
// Mod-D address pointer with clear and advance enable; wraps naturally at 2**ADDR_BITS.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    output logic [ADDR_BITS-1:0] ptr
);

    logic [ADDR_BITS-1:0] ptr_q;

    // Pointer register: reset/clear to zero, otherwise advance by one when enabled.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= ptr_q + ADDR_BITS'(1);
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ram.sv
// Simple dual-port ram: synchronous write, registered read (data_out valid next cycle).
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 write,
    input  logic                 read,
    input  logic [ADDR_BITS-1:0] addr_write,
    input  logic [ADDR_BITS-1:0] addr_read,
    input  logic [DATA_BITS-1:0] data_in,
    output logic [DATA_BITS-1:0] data_out
);

    logic [DATA_BITS-1:0] mem [1 << ADDR_BITS];
    logic [DATA_BITS-1:0] data_out_q;

    // Storage is never reset; only the addressed word moves on each port.
    always_ff @(posedge clk) begin
        if (write) mem[addr_write] <= data_in;
        if (read)  data_out_q      <= mem[addr_read];
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/fifo_top.sv
// Wrapper pairing the controller with its ram.
module fifo_top
    import fifo_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [ADDR_BITS:0]   umbral_alto,
    input  logic [ADDR_BITS:0]   umbral_bajo,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] data_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error,
    output logic [ADDR_BITS:0]   count,
    output logic [1:0]           state
);

    logic                 ram_write, ram_read;
    logic [ADDR_BITS-1:0] addr_write, addr_read;

    fifo_ctrl #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .push         (push),
        .pop          (pop),
        .ram_write    (ram_write),
        .ram_read     (ram_read),
        .addr_write   (addr_write),
        .addr_read    (addr_read),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .count        (count),
        .state        (state)
    );

    fifo_ram #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_ram (
        .clk        (clk),
        .write      (ram_write),
        .read       (ram_read),
        .addr_write (addr_write),
        .addr_read  (addr_read),
        .data_in    (data_in),
        .data_out   (data_out)
    );

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: owns pointers, occupancy, flags and the IDLE/INIT/ACTIVE/ERROR FSM
// in front of an external dual-port ram with a one-cycle registered read.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [ADDR_BITS:0]   umbral_alto,
    input  logic [ADDR_BITS:0]   umbral_bajo,
    input  logic                 push,
    input  logic                 pop,
    output logic                 ram_write,
    output logic                 ram_read,
    output logic [ADDR_BITS-1:0] addr_write,
    output logic [ADDR_BITS-1:0] addr_read,
    output logic                 data_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error,
    output logic [ADDR_BITS:0]   count,
    output logic [1:0]           state
);

    localparam int              CW      = ADDR_BITS + 1;
    localparam logic [CW-1:0]   DEPTH   = CW'(1 << ADDR_BITS);
    // The data path lives in the ram; a zero-width word would make every write meaningless.
    localparam logic            DATA_OK = (DATA_BITS > 0);

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   alto_q, alto_d;
    logic [CW-1:0]   bajo_q, bajo_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            afull_q, afull_d;
    logic            aempty_q, aempty_d;
    logic            error_q, error_d;
    logic            dvalid_q;

    logic            servicing;
    logic            push_ok, pop_ok;
    logic            overflow, underflow;
    logic            ptr_clr;
    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;

    // Access qualification: init wins over traffic, and only ACTIVE/ERROR move data.
    always_comb begin
        servicing = ((state_q == ACTIVE) || (state_q == ERROR)) && !init;
        push_ok   = servicing && push && !full_q;
        pop_ok    = servicing && pop  && !empty_q;
        overflow  = servicing && push && full_q;
        underflow = servicing && pop  && empty_q;
        ptr_clr   = (state_q == INIT);
    end

    // Next-state for FSM, occupancy, thresholds, sticky error and the registered flags.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        alto_d  = alto_q;
        bajo_d  = bajo_q;
        error_d = error_q;

        unique case (state_q)
            IDLE:    if (init) state_d = INIT;
            INIT:    if (!init) state_d = ACTIVE;
            ACTIVE: begin
                if (init)                       state_d = INIT;
                else if (overflow || underflow) state_d = ERROR;
            end
            ERROR:   if (init) state_d = INIT;
            default: state_d = IDLE;
        endcase

        if (state_q == INIT) begin
            count_d = '0;
            error_d = 1'b0;
            alto_d  = umbral_alto;
            bajo_d  = umbral_bajo;
        end else begin
            if (push_ok && !pop_ok) count_d = count_q + CW'(1);
            if (pop_ok && !push_ok) count_d = count_q - CW'(1);
            if (overflow || underflow) error_d = 1'b1;
        end

        // Flags follow the count the FIFO will hold after this edge.
        full_d   = (count_d == DEPTH);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= alto_d);
        aempty_d = (count_d <= bajo_d);
    end

    // State register for FSM, occupancy, thresholds, flags and the read-valid strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            alto_q   <= DEPTH;
            bajo_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            error_q  <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            alto_q   <= alto_d;
            bajo_q   <= bajo_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            error_q  <= error_d;
            // The ram registers its read, so the word shows up one cycle after ram_read.
            dvalid_q <= pop_ok;
        end
    end

    fifo_ptr #(.ADDR_BITS(ADDR_BITS)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (ptr_clr),
        .en    (push_ok),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.ADDR_BITS(ADDR_BITS)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (ptr_clr),
        .en    (pop_ok),
        .ptr   (rd_ptr)
    );

    assign ram_write    = push_ok && DATA_OK;
    assign ram_read     = pop_ok;
    assign addr_write   = wr_ptr;
    assign addr_read    = rd_ptr;
    assign data_valid   = dvalid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign error        = error_q;
    assign count        = count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (D=8): occupancy/flag model, local ram model and a data scoreboard.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1, init = 1'b0, push = 1'b0, pop = 1'b0;
    logic [3:0] umbral_alto = 4'd6, umbral_bajo = 4'd2;
    logic       ram_write, ram_read, data_valid;
    logic [2:0] addr_write, addr_read;
    logic       full, empty, almost_full, almost_empty, error;
    logic [3:0] count;
    logic [1:0] state;

    logic [9:0] wdata = '0;
    logic [9:0] rd_data = '0;
    logic [9:0] mem [8];
    logic [9:0] sb [$];

    int checks = 0;
    int errors = 0;
    int mcount = 0, mwp = 0, mrp = 0, mstate = 0;
    logic merr = 1'b0;

    fifo_ctrl #(.DATA_BITS(10), .ADDR_BITS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .push         (push),
        .pop          (pop),
        .ram_write    (ram_write),
        .ram_read     (ram_read),
        .addr_write   (addr_write),
        .addr_read    (addr_read),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .count        (count),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Ram model driven by the controller's strobes.
    always @(posedge clk) begin
        if (ram_write) mem[addr_write] <= wdata;
        if (ram_read)  rd_data         <= mem[addr_read];
    end

    // Scoreboard: every data_valid must deliver the oldest accepted word.
    always @(negedge clk) begin
        logic [9:0] e;
        if (data_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL dv_unexpected: data_valid=1 data=%h, expected no read pending", rd_data);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL read_data: got %h expected %h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of traffic, checked against the occupancy model before and after the edge.
    task automatic do_op(input logic p, input logic q, input logic [9:0] d);
        logic        ew, er, ovf, unf;
        logic [10:0] exp_s, got_s;
        ew  = p && (mcount < 8);
        er  = q && (mcount > 0);
        ovf = p && (mcount == 8);
        unf = q && (mcount == 0);
        push = p; pop = q; wdata = d;
        #1;
        checks++;
        if ({ram_write, ram_read} !== {ew, er}) begin
            errors++;
            $display("FAIL access: wr/rd=%b%b expected %b%b (count model %0d)", ram_write, ram_read, ew, er, mcount);
        end
        if (ew) begin
            checks++;
            if (addr_write !== 3'(mwp)) begin
                errors++;
                $display("FAIL addr_write: got %0d expected %0d", addr_write, mwp);
            end
            sb.push_back(d);
        end
        if (er) begin
            checks++;
            if (addr_read !== 3'(mrp)) begin
                errors++;
                $display("FAIL addr_read: got %0d expected %0d", addr_read, mrp);
            end
        end
        mcount = mcount + int'(ew) - int'(er);
        mwp    = (mwp + int'(ew)) % 8;
        mrp    = (mrp + int'(er)) % 8;
        if (ovf || unf) begin
            merr   = 1'b1;
            mstate = 3;
        end
        tick();
        push = 1'b0; pop = 1'b0;
        exp_s = {4'(mcount), mcount == 8, mcount == 0, mcount >= 6, mcount <= 2, merr, 2'(mstate)};
        got_s = {count, full, empty, almost_full, almost_empty, error, state};
        checks++;
        if (got_s !== exp_s) begin
            errors++;
            $display("FAIL status: {count,full,empty,af,ae,err,state}=%b expected %b", got_s, exp_s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; push = 1'b1; pop = 1'b1; init = 1'b0;
        tick(); tick();
        checks++;
        if ({state, count, empty, full, almost_full, almost_empty, error, data_valid} !== {2'd0, 4'd0, 6'b100100}) begin
            errors++;
            $display("FAIL reset_state: st=%0d cnt=%0d e/f/af/ae/err/dv=%b%b%b%b%b%b expected 0 0 100100",
                     state, count, empty, full, almost_full, almost_empty, error, data_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({ram_write, ram_read} !== 2'b00) begin
            errors++;
            $display("FAIL idle_ignore: wr/rd=%b%b expected 00", ram_write, ram_read);
        end
        tick();
        checks++;
        if ({state, count} !== {2'd0, 4'd0}) begin
            errors++;
            $display("FAIL idle_hold: st=%0d cnt=%0d expected 0 0", state, count);
        end
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_init();
        umbral_alto = 4'd6; umbral_bajo = 4'd2;
        init = 1'b1;
        tick();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL init_enter: st=%0d expected 1", state);
        end
        init = 1'b0;
        tick();
        checks++;
        if ({state, count, empty, almost_empty, error} !== {2'd2, 4'd0, 3'b110}) begin
            errors++;
            $display("FAIL init_active: st=%0d cnt=%0d empty=%b ae=%b err=%b expected 2 0 1 1 0",
                     state, count, empty, almost_empty, error);
        end
        mcount = 0; mwp = 0; mrp = 0; merr = 1'b0; mstate = 2;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) do_op(1'b1, 1'b0, 10'(i));
        do_op(1'b1, 1'b0, 10'h3ff);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) do_op(1'b0, 1'b1, '0);
        do_op(1'b0, 1'b1, '0);
    endtask

    task automatic test_init_clear();
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
        checks++;
        if ({state, count, error, empty} !== {2'd2, 4'd0, 2'b01}) begin
            errors++;
            $display("FAIL init_clear: st=%0d cnt=%0d err=%b empty=%b expected 2 0 0 1", state, count, error, empty);
        end
        mcount = 0; mwp = 0; mrp = 0; merr = 1'b0; mstate = 2;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)  do_op(1'b1, 1'b0, 10'h100 + 10'(i));
        for (int i = 0; i < 10; i++) do_op(1'b1, 1'b1, 10'h200 + 10'(i));
        checks++;
        if ({addr_write, addr_read, count} !== {3'd6, 3'd2, 4'd4}) begin
            errors++;
            $display("FAIL wrap: aw=%0d ar=%0d cnt=%0d expected 6 2 4", addr_write, addr_read, count);
        end
        for (int i = 0; i < 4; i++)  do_op(1'b0, 1'b1, '0);
    endtask

    task automatic test_reset_mid();
        do_op(1'b1, 1'b0, 10'h055);
        do_op(1'b0, 1'b1, '0);
        reset = 1'b1;
        tick();
        checks++;
        if ({data_valid, state, count, empty} !== {1'b0, 2'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: dv=%b st=%0d cnt=%0d empty=%b expected 0 0 0 1", data_valid, state, count, empty);
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_init();
        test_fill();
        test_drain();
        test_init_clear();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words never read back, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
